// File: rtl/eth_axis_tx_vlan_pad.sv
// Byte-wide Ethernet transmit framer: prepends the MAC header (with optional 802.1Q tag)
// to an AXI-Stream payload and zero-pads short frames up to a minimum length.
module eth_axis_tx_vlan_pad #(
  parameter bit          VLAN_ENABLE      = 1'b1,
  parameter logic [15:0] VLAN_TPID        = 16'h8100,
  parameter bit          PAD_ENABLE       = 1'b1,
  parameter int          MIN_FRAME_LENGTH = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic        s_eth_vlan_valid,
  input  logic [15:0] s_eth_vlan_tci,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic        pad_active
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} state_t;

  localparam logic [7:0] MinLen = 8'(MIN_FRAME_LENGTH);

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [6:0]  byteCnt_q, byteCnt_d;
  logic [47:0] destMac_q, destMac_d, srcMac_q, srcMac_d;
  logic [15:0] ethType_q, ethType_d, tci_q, tci_d;
  logic        vlan_q, vlan_d, tuserSave_q, tuserSave_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;

  logic         outLoad;
  logic [143:0] hdrWord;
  logic [7:0]   hdrByte;
  logic         hdrLast;
  logic [6:0]   cntInc;
  logic [7:0]   cntNext;

  // The output register may take a new byte whenever it is empty or being drained.
  assign outLoad   = m_axis_tready || !tvalid_q;
  assign cntInc    = (byteCnt_q == 7'd127) ? byteCnt_q : byteCnt_q + 7'd1;
  assign cntNext   = {1'b0, byteCnt_q} + 8'd1;
  assign hdrWord   = vlan_q ? {destMac_q, srcMac_q, VLAN_TPID, tci_q, ethType_q}
                            : {destMac_q, srcMac_q, ethType_q, 32'h0};
  assign hdrByte   = hdrWord[8'd143 - {ptr_q, 3'b000} -: 8];
  assign hdrLast   = (ptr_q == (vlan_q ? 5'd17 : 5'd13));

  assign s_eth_hdr_ready           = (state_q == IDLE);
  assign s_eth_payload_axis_tready = (state_q == PAYLOAD) && outLoad;
  assign busy                      = (state_q != IDLE);
  assign pad_active                = (state_q == PAD);
  assign m_axis_tdata              = tdata_q;
  assign m_axis_tvalid             = tvalid_q;
  assign m_axis_tlast              = tlast_q;
  assign m_axis_tuser              = tuser_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    byteCnt_d   = byteCnt_q;
    destMac_d   = destMac_q;
    srcMac_d    = srcMac_q;
    ethType_d   = ethType_q;
    tci_d       = tci_q;
    vlan_d      = vlan_q;
    tuserSave_d = tuserSave_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;

    unique case (state_q)
      IDLE: begin
        if (outLoad) tvalid_d = 1'b0;
        if (s_eth_hdr_valid) begin
          destMac_d = s_eth_dest_mac;
          srcMac_d  = s_eth_src_mac;
          ethType_d = s_eth_type;
          tci_d     = s_eth_vlan_tci;
          vlan_d    = VLAN_ENABLE && s_eth_vlan_valid;
          ptr_d     = 5'd0;
          byteCnt_d = 7'd0;
          state_d   = HEADER;
        end
      end
      HEADER: begin
        if (outLoad) begin
          tdata_d   = hdrByte;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tuser_d   = 1'b0;
          ptr_d     = ptr_q + 5'd1;
          byteCnt_d = cntInc;
          if (hdrLast) state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (outLoad) begin
          if (s_eth_payload_axis_tvalid) begin
            tdata_d   = s_eth_payload_axis_tdata;
            tvalid_d  = 1'b1;
            tlast_d   = 1'b0;
            tuser_d   = 1'b0;
            byteCnt_d = cntInc;
            if (s_eth_payload_axis_tlast) begin
              // A short frame defers its end marker and error flag to the last pad byte.
              if (PAD_ENABLE && (cntNext < MinLen)) begin
                tuserSave_d = s_eth_payload_axis_tuser;
                state_d     = PAD;
              end else begin
                tlast_d = 1'b1;
                tuser_d = s_eth_payload_axis_tuser;
                state_d = IDLE;
              end
            end
          end else begin
            tvalid_d = 1'b0;
          end
        end
      end
      PAD: begin
        if (outLoad) begin
          tdata_d   = 8'h00;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tuser_d   = 1'b0;
          byteCnt_d = cntInc;
          if (cntNext >= MinLen) begin
            tlast_d = 1'b1;
            tuser_d = tuserSave_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 5'd0;
      byteCnt_q   <= 7'd0;
      destMac_q   <= 48'd0;
      srcMac_q    <= 48'd0;
      ethType_q   <= 16'd0;
      tci_q       <= 16'd0;
      vlan_q      <= 1'b0;
      tuserSave_q <= 1'b0;
      tdata_q     <= 8'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      byteCnt_q   <= byteCnt_d;
      destMac_q   <= destMac_d;
      srcMac_q    <= srcMac_d;
      ethType_q   <= ethType_d;
      tci_q       <= tci_d;
      vlan_q      <= vlan_d;
      tuserSave_q <= tuserSave_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
    end
  end

endmodule

// File: tb/tb_eth_axis_tx_vlan_pad.sv
// Randomized bench for eth_axis_tx_vlan_pad: frames are rebuilt byte-by-byte from the
// header fields and payload list, and compared with the captured output stream.
module tb_eth_axis_tx_vlan_pad;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        hdrValid;
  logic [47:0] destMac, srcMac;
  logic [15:0] ethType, vlanTci;
  logic        vlanValid;
  logic [7:0]  payData;
  logic        payValid, payLast, payUser;
  logic        mReady;

  logic       aHdrReady, aPayReady, aValid, aLast, aUser, aBusy, aPad;
  logic       bHdrReady, bPayReady, bValid, bLast, bUser, bBusy, bPad;
  logic [7:0] aData, bData;

  // sel routes handshakes to the default instance (0) or the no-VLAN/no-pad instance (1).
  logic       hdrReady, payReady, obsValid, obsLast, obsUser, obsBusy, obsPad;
  logic [7:0] obsData;
  assign hdrReady = sel ? bHdrReady : aHdrReady;
  assign payReady = sel ? bPayReady : aPayReady;
  assign obsValid = sel ? bValid    : aValid;
  assign obsLast  = sel ? bLast     : aLast;
  assign obsUser  = sel ? bUser     : aUser;
  assign obsData  = sel ? bData     : aData;
  assign obsBusy  = sel ? bBusy     : aBusy;
  assign obsPad   = sel ? bPad      : aPad;

  eth_axis_tx_vlan_pad dutA (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(hdrValid && !sel), .s_eth_hdr_ready(aHdrReady),
    .s_eth_dest_mac(destMac), .s_eth_src_mac(srcMac), .s_eth_type(ethType),
    .s_eth_vlan_valid(vlanValid), .s_eth_vlan_tci(vlanTci),
    .s_eth_payload_axis_tdata(payData), .s_eth_payload_axis_tvalid(payValid && !sel),
    .s_eth_payload_axis_tready(aPayReady), .s_eth_payload_axis_tlast(payLast),
    .s_eth_payload_axis_tuser(payUser),
    .m_axis_tdata(aData), .m_axis_tvalid(aValid), .m_axis_tready(mReady && !sel),
    .m_axis_tlast(aLast), .m_axis_tuser(aUser), .busy(aBusy), .pad_active(aPad)
  );

  eth_axis_tx_vlan_pad #(.VLAN_ENABLE(1'b0), .PAD_ENABLE(1'b0)) dutB (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(hdrValid && sel), .s_eth_hdr_ready(bHdrReady),
    .s_eth_dest_mac(destMac), .s_eth_src_mac(srcMac), .s_eth_type(ethType),
    .s_eth_vlan_valid(vlanValid), .s_eth_vlan_tci(vlanTci),
    .s_eth_payload_axis_tdata(payData), .s_eth_payload_axis_tvalid(payValid && sel),
    .s_eth_payload_axis_tready(bPayReady), .s_eth_payload_axis_tlast(payLast),
    .s_eth_payload_axis_tuser(payUser),
    .m_axis_tdata(bData), .m_axis_tvalid(bValid), .m_axis_tready(mReady && sel),
    .m_axis_tlast(bLast), .m_axis_tuser(bUser), .busy(bBusy), .pad_active(bPad)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] expQ[$];
  logic [31:0] gotQ[$];
  logic [7:0]  payBytes[$];
  logic        payUserLast;
  bit          randomRate;
  bit          frameDone;
  int          busyCycles, padCycles, firstIdx, lastIdx;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] beat(input logic [7:0] d, input logic l, input logic u);
    return {22'd0, d, l, u};
  endfunction

  // Reference frame: header bytes, payload, then zeros up to 60 bytes when padding applies.
  task automatic buildExpected(input bit vlanEn, input bit padEn);
    int hdrLen, total;
    bit padNeeded;
    expQ.delete();
    for (int i = 0; i < 6; i++) expQ.push_back(beat(destMac[8*(5-i) +: 8], 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) expQ.push_back(beat(srcMac[8*(5-i) +: 8], 1'b0, 1'b0));
    if (vlanEn && vlanValid) begin
      expQ.push_back(beat(8'h81, 1'b0, 1'b0));
      expQ.push_back(beat(8'h00, 1'b0, 1'b0));
      expQ.push_back(beat(vlanTci[15:8], 1'b0, 1'b0));
      expQ.push_back(beat(vlanTci[7:0], 1'b0, 1'b0));
    end
    expQ.push_back(beat(ethType[15:8], 1'b0, 1'b0));
    expQ.push_back(beat(ethType[7:0], 1'b0, 1'b0));
    hdrLen = expQ.size();
    total = hdrLen + payBytes.size();
    padNeeded = padEn && (total < 60);
    for (int i = 0; i < payBytes.size(); i++) begin
      if (i == payBytes.size() - 1 && !padNeeded)
        expQ.push_back(beat(payBytes[i], 1'b1, payUserLast));
      else
        expQ.push_back(beat(payBytes[i], 1'b0, 1'b0));
    end
    if (padNeeded)
      for (int k = total; k < 60; k++)
        expQ.push_back(beat(8'h00, k == 59, (k == 59) ? payUserLast : 1'b0));
  endtask

  task automatic applyStimulus();
    int n;
    int i;
    bit xfer;
    @(posedge clk); #1;
    hdrValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!hdrReady && n < 200) begin n++; @(negedge clk); end
    if (!hdrReady) begin
      checkOutput("hdr_accept_timeout", 32'(hdrReady), 32'd1);
      hdrValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    hdrValid = 1'b0;
    i = 0;
    n = 0;
    while (i < payBytes.size() && n < 3000) begin
      payValid = randomRate ? 1'($urandom_range(0, 1)) : 1'b1;
      payData  = payBytes[i];
      payLast  = (i == payBytes.size() - 1);
      payUser  = payLast ? payUserLast : 1'b0;
      @(negedge clk);
      xfer = payValid && payReady;
      @(posedge clk); #1;
      if (xfer) i++;
      n++;
    end
    payValid = 1'b0;
    payLast  = 1'b0;
    payUser  = 1'b0;
    if (i < payBytes.size()) checkOutput("payload_timeout", 32'(i), 32'(payBytes.size()));
  endtask

  task automatic collectFrame();
    int n;
    bit prevStall;
    logic [31:0] prevBeat;
    n = 0;
    prevStall = 1'b0;
    prevBeat = '0;
    while (!frameDone && n < 5000) begin
      @(negedge clk);
      n++;
      if (obsBusy) busyCycles++;
      if (obsPad) padCycles++;
      if (prevStall) begin
        checkOutput("stall_valid_held", 32'(obsValid), 32'd1);
        checkOutput("stall_beat_held", beat(obsData, obsLast, obsUser), prevBeat);
      end
      prevStall = obsValid && !mReady;
      prevBeat  = beat(obsData, obsLast, obsUser);
      if (obsValid && mReady) begin
        if (gotQ.size() == 0) firstIdx = n;
        gotQ.push_back(beat(obsData, obsLast, obsUser));
        if (obsLast) begin
          lastIdx = n;
          frameDone = 1'b1;
        end
      end
    end
    if (!frameDone) begin
      checkOutput("frame_end_timeout", 32'(frameDone), 32'd1);
      frameDone = 1'b1;
    end
  endtask

  task automatic driveReady();
    while (!frameDone) begin
      @(posedge clk); #1;
      mReady = randomRate ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    mReady = 1'b1;
  endtask

  task automatic runFrame(input bit useB, input logic vlanV, input logic [15:0] tci,
                          input int len, input logic userLast, input bit randRate,
                          input bit countData, input string name);
    sel         = useB;
    destMac     = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    srcMac      = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    ethType     = 16'($urandom);
    vlanValid   = vlanV;
    vlanTci     = tci;
    payUserLast = userLast;
    randomRate  = randRate;
    payBytes.delete();
    for (int i = 0; i < len; i++) payBytes.push_back(countData ? 8'(i + 1) : 8'($urandom));
    buildExpected(!useB, !useB);
    gotQ.delete();
    frameDone  = 1'b0;
    busyCycles = 0;
    padCycles  = 0;
    firstIdx   = 0;
    lastIdx    = 0;
    fork
      applyStimulus();
      collectFrame();
      driveReady();
    join
    @(posedge clk); #1;
    checkOutput({name, "_len"}, 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s_byte%0d", name, i), gotQ[i], expQ[i]);
    if (!randRate) checkOutput({name, "_no_bubble"}, 32'(lastIdx - firstIdx + 1), 32'(expQ.size()));
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; hdrValid = 1'b0; vlanValid = 1'b0; vlanTci = '0;
    destMac = '0; srcMac = '0; ethType = '0;
    payData = '0; payValid = 1'b0; payLast = 1'b0; payUser = 1'b0; mReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tvalid", 32'(aValid), 32'd0);
    checkOutput("reset_tdata", 32'(aData), 32'd0);
    checkOutput("reset_tlast_tuser", 32'({aLast, aUser}), 32'd0);
    checkOutput("reset_busy_pad", 32'({aBusy, aPad}), 32'd0);
    rst = 1'b0;
    checkOutput("reset_hdr_ready", 32'(hdrReady), 32'd1);

    runFrame(1'b0, 1'b0, 16'h0000, 46, 1'b0, 1'b0, 1'b1, "exact_min");
    checkOutput("exact_min_busy_cycles", 32'(busyCycles), 32'd60);
    checkOutput("exact_min_pad_cycles", 32'(padCycles), 32'd0);

    runFrame(1'b0, 1'b1, 16'h6064, 10, 1'b0, 1'b0, 1'b0, "tagged_pad");
    checkOutput("tagged_pad_cycles", 32'(padCycles), 32'd32);

    runFrame(1'b0, 1'b0, 16'h0000, 1, 1'b1, 1'b0, 1'b1, "one_byte_tuser");
    checkOutput("one_byte_pad_cycles", 32'(padCycles), 32'd45);

    for (int f = 0; f < 20; f++)
      runFrame(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 80),
               1'($urandom_range(0, 1)), 1'b1, 1'b0, $sformatf("rand%0d", f));

    runFrame(1'b1, 1'b1, 16'h1234, 5, 1'b0, 1'b0, 1'b1, "novlan_nopad");
    sel = 1'b0;

    // Abort a frame mid-payload, then confirm the next frame starts cleanly.
    @(posedge clk); #1;
    destMac = 48'h0102_0304_0506; srcMac = 48'h0A0B_0C0D_0E0F; ethType = 16'h0800;
    vlanValid = 1'b0; hdrValid = 1'b1;
    @(posedge clk); #1;
    hdrValid = 1'b0; payValid = 1'b1; payData = 8'hAA; payLast = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", 32'(aBusy), 32'd1);
    rst = 1'b1; payValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_tvalid", 32'(aValid), 32'd0);
    checkOutput("midreset_tdata", 32'(aData), 32'd0);
    checkOutput("midreset_tlast_tuser", 32'({aLast, aUser}), 32'd0);
    checkOutput("midreset_busy_pad", 32'({aBusy, aPad}), 32'd0);
    rst = 1'b0;
    checkOutput("midreset_hdr_ready", 32'(hdrReady), 32'd1);
    runFrame(1'b0, 1'b1, 16'hABCD, 30, 1'b1, 1'b0, 1'b1, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_axis_tx_vlan_pad.md
# eth_axis_tx_vlan_pad

Byte-wide Ethernet frame transmitter: merges parallel header fields with an AXI-Stream payload into one AXI-Stream frame. Beyond basic header prepend, it optionally inserts a per-frame 802.1Q VLAN tag and zero-pads short frames to a minimum length. It sits between the UDP/IP transmit path and the MAC; FCS is appended downstream.

## Interface

- VLAN_ENABLE, 1: 1 = VLAN insertion logic present; 0 = `s_eth_vlan_*` ignored, always untagged.
- VLAN_TPID, 16'h8100: TPID written in the inserted tag.
- PAD_ENABLE, 1: 1 = pad frames shorter than MIN_FRAME_LENGTH; 0 = never pad.
- MIN_FRAME_LENGTH, 60: minimum frame bytes excluding FCS, header included, range 18..127.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_eth_hdr_valid  in  1  header valid
- s_eth_hdr_ready  out  1  header accepted when valid and ready are both high
- s_eth_dest_mac  in  48  destination MAC, MSB byte sent first
- s_eth_src_mac  in  48  source MAC
- s_eth_type  in  16  EtherType
- s_eth_vlan_valid  in  1  frame carries a VLAN tag, sampled with the header
- s_eth_vlan_tci  in  16  PCP/DEI/VID
- s_eth_payload_axis_tdata  in  8  payload byte
- s_eth_payload_axis_tvalid  in  1
- s_eth_payload_axis_tready  out  1
- s_eth_payload_axis_tlast  in  1
- s_eth_payload_axis_tuser  in  1  bad-frame flag, meaningful on tlast
- m_axis_tdata  out  8
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tuser  out  1
- busy  out  1  high from header accept until final output byte is accepted into the output register
- pad_active  out  1  high while pad bytes are being generated

## Operation

- FSM states: IDLE, HEADER, PAYLOAD, PAD.
- IDLE: `s_eth_hdr_ready` = 1.
  - On handshake, latch MACs, type, vlan_valid (forced 0 if !VLAN_ENABLE) and tci.
  - Clear ptr and byte_cnt, then go to HEADER.
- HEADER: emit one byte per output-register load, in this order:
  - dest[47:40]..dest[7:0], then src[47:40]..src[7:0].
  - If tagged: TPID[15:8], TPID[7:0], TCI[15:8], TCI[7:0].
  - Then type[15:8], type[7:0].
  - Header length is 14 untagged or 18 tagged. After the last header byte, go to PAYLOAD.
- PAYLOAD: pass input bytes through.
  - `s_eth_payload_axis_tready` = (state==PAYLOAD) && (m_axis_tready || !m_axis_tvalid).
  - On a tlast beat with PAD_ENABLE and byte_cnt+1 < MIN_FRAME_LENGTH:
    - output tlast=0 and tuser=0 for that beat;
    - store tuser in tuser_save;
    - go to PAD.
  - Otherwise the tlast beat passes tlast/tuser through and the FSM goes to IDLE.
- PAD: emit 8'h00 until byte_cnt reaches MIN_FRAME_LENGTH.
  - The final pad byte carries tlast=1 and tuser=tuser_save.
  - Then go to IDLE.
  - `s_eth_payload_axis_tready` = 0 throughout.
- byte_cnt: 7 bits, counts every byte loaded to output, header included. It saturates at 127; at saturation no further padding decision is needed.
- `s_eth_payload_axis_tready` = 0 in IDLE and HEADER.
- `s_eth_hdr_ready` = 0 in every state except IDLE.
- The payload must contain at least one beat; a zero-length payload is not supported.

## Timing

- Reset (rst high at a clk edge) forces, from that edge onward:
  - state IDLE;
  - m_axis_tvalid, tlast, tuser = 0 and m_axis_tdata = 0;
  - busy, pad_active = 0.
  - `s_eth_hdr_ready` = 1 in the first cycle after reset deasserts.
  - A frame in progress is abandoned without a tlast; downstream must tolerate this.
- Output stage: a single register. It loads when m_axis_tready || !m_axis_tvalid. When there is no load, every output holds.
- Latency:
  - header handshake at edge N; first dest byte valid on m_axis after edge N+1;
  - with m_axis_tready held high, one byte per cycle with no bubbles across HEADER to PAYLOAD to PAD boundaries;
  - payload byte accepted at edge K appears on m_axis after edge K.
- Back-to-back frames: the next header can be accepted in the cycle the FSM returns to IDLE. This leaves one idle output cycle between frames.
- m_axis_tready low: the output holds. tvalid never drops without a transfer, and tdata/tlast/tuser stay stable.
- s_eth_hdr_valid during HEADER, PAYLOAD or PAD: ignored (ready=0), with no side effects.
- Exactly at minimum: payload tlast with byte_cnt+1 == MIN_FRAME_LENGTH means no padding; tlast passes through.

## Test plan

- Untagged frame with a 46-byte payload (0x01..0x2E), tready=1:
  - 60 output bytes; byte 12..13 = type;
  - tlast only on byte 60 (0x2E); no PAD entry; busy high for 60 cycles.
- Tagged frame, TCI=16'h6064, 10-byte payload:
  - bytes 12..15 = 81 00 60 64;
  - bytes 28..59 = 0x00; tlast on byte 60;
  - pad_active high for 32 cycles.
- Untagged, 1-byte payload with tuser=1 on tlast:
  - payload byte has tuser=0, tlast=0;
  - 45 zero pad bytes follow, the last with tlast=1, tuser=1.
- Random m_axis_tready (50%) and random payload tvalid across 20 frames of mixed tag/length:
  - the output byte sequence matches the reference model;
  - no data change while tvalid && !tready.
- VLAN_ENABLE=0 with s_eth_vlan_valid=1: the output is untagged (14-byte header).
- PAD_ENABLE=0 with a 5-byte payload: a 19-byte frame with tlast on byte 19.
- rst pulsed mid-payload:
  - all outputs are 0 on the next cycle and s_eth_hdr_ready=1 after release;
  - the following frame is correct from dest byte 0.
